// File: rtl/mcu_mem_master_pkg.sv
// Shared definitions for the MCU memory-request master: handshake widths,
// one-hot FSM encoding and the masked address-increment helper.
package mcu_mem_master_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 16;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_ISSUE   = 5'b00010,
    ST_WAIT_LO = 5'b00100,
    ST_WAIT_HI = 5'b01000,
    ST_NEXT    = 5'b10000
  } mm_state_e;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [ADDR_W-1:0] mask);
    return (addr + 24'd1) & mask;
  endfunction

endpackage

// File: rtl/mcu_rd_fifo.sv
// Small synchronous FIFO holding read bytes for the SPI output path.
// Pops of an empty FIFO are dropped; push and pop may share a cycle.
module mcu_rd_fifo
  import mcu_mem_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);
  localparam logic [PTR_W-1:0] PONE_C  = PTR_W'(1);
  localparam logic [PTR_W-1:0] PZERO_C = PTR_W'(0);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_pop_s;
  logic              do_push_s;

  // Qualify push/pop against occupancy; a pop frees room for a same-cycle push.
  always_comb begin
    do_pop_s  = pop & (count_r != ZERO_C);
    do_push_s = push & ((count_r != DEPTH_C) | do_pop_s);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= PZERO_C;
      rd_ptr_r <= PZERO_C;
      count_r  <= ZERO_C;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'd0;
      end
    end else if (flush) begin
      wr_ptr_r <= PZERO_C;
      rd_ptr_r <= PZERO_C;
      count_r  <= ZERO_C;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PONE_C;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PONE_C;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign count     = count_r;

endmodule

// File: rtl/mcu_mem_master.sv
// Burst initiator on the MCU request handshake: one command becomes a train of
// single-byte rrq/wrq requests paced by the arbiter's rdy low/high cycle.
module mcu_mem_master
  import mcu_mem_master_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] RDY_TIMEOUT = 16'd4095
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [ADDR_W-1:0] addr_mask,
  input  logic              abort,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              mcu_rrq,
  output logic              mcu_wrq,
  output logic [ADDR_W-1:0] mcu_addr,
  output logic [DATA_W-1:0] mcu_dout,
  input  logic [DATA_W-1:0] mcu_din,
  input  logic              mcu_rdy,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  mm_state_e         state_r, state_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] dout_r, dout_s;
  logic              write_r, write_s;
  logic              err_r, err_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              rrq_r, rrq_s;
  logic              wrq_r, wrq_s;
  logic              abort_pend_r, abort_pend_s;
  logic [15:0]       tmo_cnt_r;
  logic              tmo_hit_s;
  logic              push_s;
  logic              flush_s;
  logic              wr_ready_s;
  logic [CNT_W-1:0]  fifo_count_s;

  // Next-state, request pulses and burst bookkeeping.
  always_comb begin
    state_s      = state_r;
    len_s        = len_r;
    addr_s       = addr_r;
    dout_s       = dout_r;
    write_s      = write_r;
    err_s        = err_r;
    busy_s       = busy_r;
    done_s       = 1'b0;
    rrq_s        = 1'b0;
    wrq_s        = 1'b0;
    abort_pend_s = abort_pend_r;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    wr_ready_s   = 1'b0;
    tmo_hit_s    = (tmo_cnt_r == (RDY_TIMEOUT - 16'd1));
    case (state_r)
      ST_IDLE: begin
        abort_pend_s = 1'b0;
        if (cmd_valid) begin
          write_s = cmd_write;
          len_s   = cmd_len;
          addr_s  = cmd_addr & addr_mask;
          err_s   = 1'b0;
          flush_s = ~cmd_write;
          if (cmd_len == 16'd0) begin
            done_s = 1'b1;
            busy_s = 1'b0;
          end else begin
            busy_s  = 1'b1;
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else if (write_r) begin
          if (wr_valid) begin
            wr_ready_s = 1'b1;
            dout_s     = wr_data;
            wrq_s      = 1'b1;
            state_s    = ST_WAIT_LO;
          end else begin
            state_s = ST_ISSUE;
          end
        end else if (fifo_count_s < DEPTH_C) begin
          // Nothing is outstanding here, so a free slot guarantees room for the reply.
          rrq_s   = 1'b1;
          state_s = ST_WAIT_LO;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT_LO: begin
        abort_pend_s = abort_pend_r | abort;
        if (!mcu_rdy) begin
          state_s = ST_WAIT_HI;
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT_LO;
        end
      end
      ST_WAIT_HI: begin
        if (mcu_rdy) begin
          push_s = ~write_r;
          if (abort_pend_r | abort) begin
            done_s  = 1'b1;
            busy_s  = 1'b0;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_NEXT;
          end
        end else if (tmo_hit_s) begin
          err_s   = 1'b1;
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          abort_pend_s = abort_pend_r | abort;
          state_s      = ST_WAIT_HI;
        end
      end
      ST_NEXT: begin
        len_s  = len_r - 16'd1;
        addr_s = next_addr(addr_r, addr_mask);
        if (len_r == 16'd1) begin
          done_s  = 1'b1;
          busy_s  = 1'b0;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        busy_s  = 1'b0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      len_r        <= 16'd0;
      addr_r       <= 24'd0;
      dout_r       <= 8'd0;
      write_r      <= 1'b0;
      err_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rrq_r        <= 1'b0;
      wrq_r        <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      addr_r       <= addr_s;
      dout_r       <= dout_s;
      write_r      <= write_s;
      err_r        <= err_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      rrq_r        <= rrq_s;
      wrq_r        <= wrq_s;
      abort_pend_r <= abort_pend_s;
    end
  end

  // rdy watchdog: restarts on every state change, counts only while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt_r <= 16'd0;
    end else if (state_s != state_r) begin
      tmo_cnt_r <= 16'd0;
    end else if ((state_r == ST_WAIT_LO) || (state_r == ST_WAIT_HI)) begin
      tmo_cnt_r <= tmo_cnt_r + 16'd1;
    end else begin
      tmo_cnt_r <= 16'd0;
    end
  end

  mcu_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_s),
    .push      (push_s),
    .push_data (mcu_din),
    .pop       (rd_ready),
    .head_data (rd_data),
    .count     (fifo_count_s)
  );

  assign rd_valid = (fifo_count_s != {CNT_W{1'b0}});
  assign wr_ready = wr_ready_s;
  assign mcu_rrq  = rrq_r;
  assign mcu_wrq  = wrq_r;
  assign mcu_addr = addr_r;
  assign mcu_dout = dout_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: doc/mcu_mem_master.md
Name: mcu_mem_master

Overview:
- Initiator side of the MCU memory-request handshake (rrq/wrq pulse, rdy low/high, din/dout) served by the master control FSM's MCU path.
- Turns one burst command (start address, byte count, direction) into a sequence of single-byte requests with auto-incrementing address.
- Paces requests on the arbiter's rdy. Buffers read bytes in a small FIFO for the SPI output path. Pulls write bytes from a valid/ready stream.

Parameters:
- FIFO_DEPTH, 4, read-data FIFO entries (power of two, >=2)
- RDY_TIMEOUT, 16'd4095, clk cycles to wait for any rdy edge before flagging an error

Ports:
- clk  in  1  system clock (CLK2 domain)
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  start burst; sampled only in IDLE
- cmd_write  in  1  1=write burst, 0=read burst
- cmd_addr  in  24  start byte address
- cmd_len  in  16  byte count; 0 means no transfer
- addr_mask  in  24  address wrap mask (ROM_MASK/SAVERAM_MASK)
- abort  in  1  terminate burst
- wr_data  in  8  write byte
- wr_valid  in  1  write byte available
- wr_ready  out  1  write byte consumed this cycle
- rd_data  out  8  FIFO head byte
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  pop FIFO head
- mcu_rrq  out  1  one-cycle read request pulse
- mcu_wrq  out  1  one-cycle write request pulse
- mcu_addr  out  24  request address, held stable from pulse until completion
- mcu_dout  out  8  write data, held stable from pulse until completion
- mcu_din  in  8  read data; valid when rdy returns high
- mcu_rdy  in  1  arbiter ready (1=idle)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst end (normal, abort or error)
- err  out  1  sticky rdy-timeout flag; cleared by next accepted cmd_valid

Behaviour:
- Reset: all outputs 0 except mcu_addr=0 and mcu_dout=0 (also 0). FIFO empty, state IDLE, counters 0. Reset mid-burst drops everything with no done pulse.
- States: IDLE, ISSUE, WAIT_LO, WAIT_HI, NEXT.
- IDLE, cmd_valid=1:
  - Latch direction and len. Set addr = cmd_addr & addr_mask. Clear err. busy=1.
  - len=0: done the next cycle, busy drops with it, no request issued.
  - Otherwise -> ISSUE.
- ISSUE, write burst: wait for wr_valid. In the accept cycle wr_ready=1, latch mcu_dout, pulse mcu_wrq for 1 cycle -> WAIT_LO.
- ISSUE, read burst: wait until the FIFO has a free slot. Counted slots include the outstanding request, so a read is never issued into a full FIFO. Pulse mcu_rrq for 1 cycle -> WAIT_LO.
- WAIT_LO: wait for mcu_rdy=0. The arbiter lowers rdy the cycle after the pulse; a rdy=1 seen in the pulse cycle is ignored -> WAIT_HI.
- WAIT_HI: wait for mcu_rdy=1.
  - Read: push mcu_din into the FIFO in that same cycle.
  - -> NEXT.
- NEXT:
  - len-=1; addr = (addr+1) & addr_mask. Wrap is therefore modulo mask+1.
  - len reaches 0: done pulse, busy=0 -> IDLE. Else -> ISSUE.
  - Minimum 4 cycles per byte.
- Timeout: a counter runs in WAIT_LO and WAIT_HI and reloads on each state entry. On reaching RDY_TIMEOUT: err=1, done pulse -> IDLE.
- abort:
  - In ISSUE: immediate done -> IDLE.
  - In WAIT_LO or WAIT_HI: the outstanding request completes first (a read still pushes), then done -> IDLE.
  - Ignored in IDLE.
- FIFO:
  - Simultaneous push and pop allowed; the count is unchanged.
  - Pop when empty is ignored.
  - rd_data is the registered head.
  - FIFO contents survive the end of a burst; only reset or a new read cmd_valid flushes it.
- cmd_valid while busy: ignored.
- mcu_rrq and mcu_wrq are never high together and never re-pulse before rdy has gone low and back high.

Decomposition:
- Shared package: state encoding constants (one-hot, matching the master FSM style) and the MCU handshake widths (ADDR_W=24, DATA_W=8).
- One sub-module: mcu_rd_fifo (synchronous FIFO with count output).

Test Plan:
- Read burst, addr=0x000010, len=3, mask=0xFFFFFF, arbiter model returns din=addr[7:0] 8 cycles after rrq -> exactly 3 rrq pulses at addrs 0x10, 0x11, 0x12; FIFO pops 0x10, 0x11, 0x12; one done pulse.
- Write burst, addr=0x7FFFFE, len=4, mask=0x7FFFFF, wr_valid gapped every other cycle -> wrq at 0x7FFFFE, 0x7FFFFF, 0x000000, 0x000001; mcu_dout matches the stream; wr_ready high exactly 4 times.
- FIFO_DEPTH=4, read len=6, rd_ready=0 -> exactly 4 rrq then stall. Raising rd_ready resumes, and 6 bytes arrive in order.
- mcu_rdy stuck low after rrq -> after 4095 cycles err=1 and done pulses. Next cmd_valid clears err.
- abort asserted in WAIT_HI of byte 2 of a len=5 read -> byte 2 is still pushed, no further rrq, done one cycle after completion.
- len=0 command -> done on the next cycle, no rrq or wrq. rst_n=0 mid-burst -> all outputs 0, FIFO empty, no done.
